// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet header dispatch path: EtherType
// constants, VLAN tag identifiers, dispatch one-hot encodings, FSM states.
package eth_pkg;

  localparam logic [15:0] ETH_IPV4 = 16'h0800;
  localparam logic [15:0] ETH_IPV6 = 16'h86dd;
  localparam logic [15:0] TPID_Q   = 16'h8100;
  localparam logic [15:0] TPID_AD  = 16'h88a8;

  // one-hot {other, ipv6, ipv4}
  localparam logic [2:0] SEL_IPV4  = 3'b001;
  localparam logic [2:0] SEL_IPV6  = 3'b010;
  localparam logic [2:0] SEL_OTHER = 3'b100;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MAC   = 3'd1,
    TYPE  = 3'd2,
    TCI   = 3'd3,
    CLASS = 3'd4,
    DISP  = 3'd5,
    DRAIN = 3'd6
  } state_e;

endpackage

// File: rtl/eth_type_decode.sv
// EtherType to one-hot class decode. Purely combinational so the caller
// decides when to register it (also used by the IPv6 extension walker).
module eth_type_decode
  import eth_pkg::*;
(
  input  logic [15:0] eth_type,
  output logic [2:0]  sel
);

  // anything not IPv4/IPv6 falls into the "other" bucket
  always_comb begin
    sel = SEL_OTHER;
    if (eth_type == ETH_IPV4) begin
      sel = SEL_IPV4;
    end else if (eth_type == ETH_IPV6) begin
      sel = SEL_IPV6;
    end
  end

endmodule

// File: rtl/eth_hdr_dispatch.sv
// Ingress header sequencer: skips DA/SA, up to MAX_VLAN tags, captures the
// EtherType and hands one classified record per frame downstream.
//
// state | meaning
// IDLE  | waiting for a sop word (word 0 of DA)
// MAC   | consuming DA/SA words 1..5
// TYPE  | next word is a candidate EtherType or a tag TPID
// TCI   | discarding the TCI word of a skipped tag
// CLASS | input stalled, decoding the latched EtherType
// DISP  | record presented until out_ready
// DRAIN | discarding payload up to eop
module eth_hdr_dispatch #(
  parameter int          MAX_VLAN = 2,
  parameter logic [15:0] TPID_Q   = 16'h8100,
  parameter logic [15:0] TPID_AD  = 16'h88a8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  input  logic        in_sop,
  input  logic        in_eop,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_eth_type,
  output logic [1:0]  out_vlan_cnt,
  output logic [2:0]  out_sel,
  output logic        err_trunc
);

  import eth_pkg::*;

  localparam logic [2:0] MAX_VLAN_W = 3'(MAX_VLAN);
  localparam logic [2:0] LAST_MAC   = 3'd5;

  state_e      state_q, state_d;
  logic [2:0]  word_cnt_q, word_cnt_d;
  logic [1:0]  vlan_cnt_q, vlan_cnt_d;
  logic [15:0] eth_type_q, eth_type_d;
  logic [2:0]  sel_q, sel_d;
  logic        eop_type_q, eop_type_d;
  logic        err_q, err_d;

  logic [2:0]  dec_sel;
  logic        accept;
  logic        tag_room;
  logic        is_tag;

  eth_type_decode u_type_decode (
    .eth_type (eth_type_q),
    .sel      (dec_sel)
  );

  assign accept   = in_valid & in_ready;
  assign tag_room = ({1'b0, vlan_cnt_q} < MAX_VLAN_W);
  // a TPID beyond the tag budget is reported as the EtherType itself
  assign is_tag   = ((in_data == TPID_Q) || (in_data == TPID_AD)) && tag_room;

  // state and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      word_cnt_q <= 3'd0;
      vlan_cnt_q <= 2'd0;
      eth_type_q <= 16'h0000;
      sel_q      <= 3'b000;
      eop_type_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      vlan_cnt_q <= vlan_cnt_d;
      eth_type_q <= eth_type_d;
      sel_q      <= sel_d;
      eop_type_q <= eop_type_d;
      err_q      <= err_d;
    end
  end

  // next-state and datapath update; sop always wins and restarts the frame
  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    vlan_cnt_d = vlan_cnt_q;
    eth_type_d = eth_type_q;
    sel_d      = sel_q;
    eop_type_d = eop_type_q;
    err_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept && in_sop) begin
          word_cnt_d = 3'd1;
          vlan_cnt_d = 2'd0;
          state_d    = MAC;
        end
      end

      MAC: begin
        if (accept) begin
          if (in_sop) begin
            err_d      = 1'b1;
            word_cnt_d = 3'd1;
            vlan_cnt_d = 2'd0;
            state_d    = MAC;
          end else if (in_eop) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            word_cnt_d = (word_cnt_q == 3'd7) ? word_cnt_q : word_cnt_q + 3'd1;
            if (word_cnt_q == LAST_MAC) begin
              state_d = TYPE;
            end
          end
        end
      end

      TYPE: begin
        if (accept) begin
          if (in_sop) begin
            err_d      = 1'b1;
            word_cnt_d = 3'd1;
            vlan_cnt_d = 2'd0;
            state_d    = MAC;
          end else if (is_tag) begin
            // a frame ending on a tag TPID never reached its EtherType
            if (in_eop) begin
              err_d   = 1'b1;
              state_d = IDLE;
            end else begin
              vlan_cnt_d = vlan_cnt_q + 2'd1;
              state_d    = TCI;
            end
          end else begin
            eth_type_d = in_data;
            eop_type_d = in_eop;
            state_d    = CLASS;
          end
        end
      end

      TCI: begin
        if (accept) begin
          if (in_sop) begin
            err_d      = 1'b1;
            word_cnt_d = 3'd1;
            vlan_cnt_d = 2'd0;
            state_d    = MAC;
          end else if (in_eop) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = TYPE;
          end
        end
      end

      CLASS: begin
        sel_d   = dec_sel;
        state_d = DISP;
      end

      DISP: begin
        if (out_ready) begin
          state_d = eop_type_q ? IDLE : DRAIN;
        end
      end

      DRAIN: begin
        if (accept) begin
          if (in_sop) begin
            word_cnt_d = 3'd1;
            vlan_cnt_d = 2'd0;
            state_d    = MAC;
          end else if (in_eop) begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // handshake outputs decoded from the registered state only
  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    case (state_q)
      CLASS: begin
        in_ready = 1'b0;
      end
      DISP: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
      end
      default: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
      end
    endcase
  end

  assign out_eth_type = eth_type_q;
  assign out_vlan_cnt = vlan_cnt_q;
  assign out_sel      = sel_q;
  assign err_trunc    = err_q;

endmodule

// File: tb/tb_eth_hdr_dispatch.sv
// Bench for eth_hdr_dispatch: directed timing cases plus random frames
// checked against a frame-level outcome model.
module tb_eth_hdr_dispatch;

  localparam int MAXV = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_sop;
  logic        in_eop;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_eth_type;
  logic [1:0]  out_vlan_cnt;
  logic [2:0]  out_sel;
  logic        err_trunc;

  eth_hdr_dispatch #(
    .MAX_VLAN (MAXV),
    .TPID_Q   (16'h8100),
    .TPID_AD  (16'h88a8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_sop       (in_sop),
    .in_eop       (in_eop),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_eth_type (out_eth_type),
    .out_vlan_cnt (out_vlan_cnt),
    .out_sel      (out_sel),
    .err_trunc    (err_trunc)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_err;
    logic [15:0] et;
    logic [1:0]  vc;
    logic [2:0]  sel;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] frm[$];
  bit          frm_eop;

  int checks = 0;
  int errors = 0;
  int rdy_mode = 0;
  int hs_cnt = 0;
  int err_cnt = 0;
  int valid_rise_cyc = -1;
  int err_cyc = -1;
  int sop_cyc = -1;
  logic prev_valid = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // outcome of one frame from the header rules: words 0..5 are MACs, then
  // tag/TCI pairs up to MAXV, then the EtherType; running out of words first
  // (eop or a following sop) is a truncation
  function automatic exp_t ref_model();
    exp_t e;
    int   i;
    int   nv;
    e.is_err = 1'b1;
    e.et     = 16'h0;
    e.vc     = 2'd0;
    e.sel    = 3'b000;
    nv = 0;
    i  = 6;
    while (i < frm.size()) begin
      if ((frm[i] == 16'h8100 || frm[i] == 16'h88a8) && nv < MAXV) begin
        if (i + 2 >= frm.size()) return e;
        nv++;
        i += 2;
      end else begin
        e.is_err = 1'b0;
        e.et     = frm[i];
        e.vc     = 2'(nv);
        e.sel    = (frm[i] == 16'h0800) ? 3'b001 :
                   (frm[i] == 16'h86dd) ? 3'b010 : 3'b100;
        return e;
      end
    end
    return e;
  endfunction

  // out_ready driver and output monitor
  always @(negedge clk) begin
    exp_t e;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
    if (rst === 1'b1) begin
      if (out_valid && !prev_valid) valid_rise_cyc = cyc;
      if (out_valid && out_ready) begin
        hs_cnt++;
        chk("rec_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("rec_kind", e.is_err, 0);
          chk("eth_type", out_eth_type, e.et);
          chk("vlan_cnt", out_vlan_cnt, e.vc);
          chk("sel", out_sel, e.sel);
        end
      end
      if (err_trunc) begin
        err_cnt++;
        err_cyc = cyc;
        chk("err_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("err_kind", e.is_err, 1);
        end
      end
    end
    prev_valid = out_valid;
  end

  task automatic send_word(input logic [15:0] d, input bit s, input bit e);
    bit rdy;
    int sc;
    int n;
    n = 0;
    in_data  = d;
    in_sop   = s;
    in_eop   = e;
    in_valid = 1'b1;
    forever begin
      rdy = in_ready;
      sc  = cyc;
      @(negedge clk);
      if (rdy) break;
      n++;
      if (n > 200) begin
        chk("accept_timeout", n, 0);
        break;
      end
    end
    if (rdy && s) sop_cyc = sc;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
  endtask

  task automatic send_frame(input bit gaps);
    exp_q.push_back(ref_model());
    for (int i = 0; i < frm.size(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) @(negedge clk);
      send_word(frm[i], i == 0, frm_eop && (i == frm.size() - 1));
    end
  endtask

  task automatic build_hdr(input logic [15:0] t0, input logic [15:0] t1, input logic [15:0] t2,
                           input int ntags, input int npay);
    frm.delete();
    for (int i = 0; i < 6; i++) frm.push_back(16'($urandom));
    if (ntags >= 1) begin frm.push_back(t0); frm.push_back(16'($urandom)); end
    if (ntags >= 2) begin frm.push_back(t1); frm.push_back(16'($urandom)); end
    frm.push_back(t2);
    for (int i = 0; i < npay; i++) frm.push_back(16'($urandom));
    frm_eop = 1'b1;
  endtask

  task automatic build_random(input bit force_full);
    int            nt;
    int            r;
    int            cut;
    logic [15:0]   tp;
    logic [15:0]   ty;
    frm.delete();
    for (int i = 0; i < 6; i++) frm.push_back(16'($urandom));
    nt = $urandom_range(0, 3);
    for (int t = 0; t < nt; t++) begin
      tp = ($urandom_range(0, 1) == 0) ? 16'h8100 : 16'h88a8;
      frm.push_back(tp);
      frm.push_back(16'($urandom));
    end
    case ($urandom_range(0, 4))
      0:       ty = 16'h0800;
      1:       ty = 16'h86dd;
      2:       ty = 16'h8100;
      3:       ty = 16'h88a8;
      default: ty = 16'($urandom);
    endcase
    frm.push_back(ty);
    r = $urandom_range(0, 4);
    for (int i = 0; i < r; i++) frm.push_back(16'($urandom));
    frm_eop = 1'b1;
    r = force_full ? 9 : $urandom_range(0, 9);
    if (r < 3) begin
      cut = $urandom_range(2, frm.size());
      while (frm.size() > cut) void'(frm.pop_back());
      frm_eop = (r != 2);
    end
  endtask

  task automatic wait_valid(input int lim);
    int n;
    n = 0;
    while (!out_valid && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("valid_timeout", n < lim, 1);
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_in_ready"}, in_ready, 1);
    chk({pfx, "_out_valid"}, out_valid, 0);
    chk({pfx, "_eth_type"}, out_eth_type, 16'h0000);
    chk({pfx, "_vlan_cnt"}, out_vlan_cnt, 0);
    chk({pfx, "_sel"}, out_sel, 3'b000);
    chk({pfx, "_err"}, err_trunc, 0);
  endtask

  initial begin
    int hs0;
    int err0;
    int n;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
    in_data  = 16'h0;
    rst      = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    rst = 1'b1;
    @(negedge clk);

    // untagged IPv4, full rate
    rdy_mode = 0;
    valid_rise_cyc = -1;
    build_hdr(16'h0, 16'h0, 16'h0800, 0, 20);
    send_frame(0);
    chk("lat_ipv4", valid_rise_cyc - sop_cyc, 8);

    // double-tagged IPv6
    valid_rise_cyc = -1;
    build_hdr(16'h88a8, 16'h8100, 16'h86dd, 2, 5);
    send_frame(0);
    chk("lat_ipv6_2tag", valid_rise_cyc - sop_cyc, 12);

    // third TPID reported as the EtherType
    valid_rise_cyc = -1;
    build_hdr(16'h8100, 16'h88a8, 16'h8100, 2, 4);
    send_frame(0);
    chk("lat_3tag", valid_rise_cyc - sop_cyc, 12);

    // truncation: eop on word 4
    err_cyc = -1;
    err0 = err_cnt;
    build_hdr(16'h0, 16'h0, 16'h0800, 0, 0);
    while (frm.size() > 5) void'(frm.pop_back());
    send_frame(0);
    @(negedge clk);
    #1;
    chk("trunc_err_lat", err_cyc - sop_cyc, 5);
    chk("trunc_err_cnt", err_cnt - err0, 1);
    build_hdr(16'h88a8, 16'h0, 16'h0800, 1, 3);
    send_frame(1);

    // backpressure with eop on the type word
    rdy_mode = 2;
    hs0 = hs_cnt;
    build_hdr(16'h0, 16'h0, 16'h0800, 0, 0);
    send_frame(0);
    wait_valid(20);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      chk("bp_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_type", out_eth_type, 16'h0800);
    end
    rdy_mode = 0;
    n = 0;
    while (hs_cnt == hs0 && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("bp_hs_seen", hs_cnt - hs0, 1);
    @(negedge clk);
    #1;
    chk("bp_ready_back", in_ready, 1);
    chk("bp_valid_drop", out_valid, 0);
    repeat (3) @(negedge clk);
    chk("bp_single_hs", hs_cnt - hs0, 1);

    // reset in the middle of a frame
    err0 = err_cnt;
    build_hdr(16'h0, 16'h0, 16'h86dd, 0, 2);
    for (int i = 0; i < 3; i++) send_word(frm[i], i == 0, 1'b0);
    rst = 1'b0;
    #1;
    chk_reset_vals("midrst");
    @(negedge clk);
    rst = 1'b1;
    for (int i = 3; i < frm.size(); i++) send_word(frm[i], 1'b0, i == frm.size() - 1);
    build_hdr(16'h8100, 16'h0, 16'h86dd, 1, 2);
    send_frame(1);
    repeat (4) @(negedge clk);
    chk("midrst_no_err", err_cnt - err0, 0);

    // random frames with gaps, garbage and random out_ready
    rdy_mode = 1;
    for (int f = 0; f < 60; f++) begin
      build_random(f == 59);
      send_frame(1);
      if (frm_eop && $urandom_range(0, 3) == 0) send_word(16'($urandom), 1'b0, 1'b0);
    end

    rdy_mode = 0;
    repeat (40) @(negedge clk);
    chk("exp_q_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
